// File: rtl/uart_disp_frame_ctrl.sv
// UART byte-stream framer feeding the 8-digit display with checked 32-bit words.
// Ports: Clk/Reset_n, Rx_Data/Rx_Done in; Disp_Data, Frame_Ok, Frame_Err, Busy out.
module uart_disp_frame_ctrl #(
  parameter logic [7:0]  HEADER      = 8'hAA,
  parameter int unsigned TIMEOUT_CYC = 500_000,
  parameter logic [31:0] RESET_DISP  = 32'h0
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [7:0]  Rx_Data,
  input  logic        Rx_Done,
  output logic [31:0] Disp_Data,
  output logic        Frame_Ok,
  output logic        Frame_Err,
  output logic        Busy
);

  localparam int TW =
    (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] T_LAST =
    TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    CHK
  } state_t;

  state_t        state;
  logic [1:0]    cnt;
  logic [7:0]    sum;
  logic [TW-1:0] tcnt;
  logic [31:0]   shreg;

  // Idle gap has reached its limit this cycle
  logic expired;
  assign expired = !Rx_Done && (tcnt == T_LAST);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      sum       <= 8'd0;
      tcnt      <= '0;
      shreg     <= 32'd0;
      Disp_Data <= RESET_DISP;
      Frame_Ok  <= 1'b0;
      Frame_Err <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      Frame_Ok  <= 1'b0;
      Frame_Err <= 1'b0;
      unique case (state)
        IDLE: begin
          tcnt <= '0;
          if (Rx_Done && Rx_Data == HEADER) begin
            state <= DATA;
            Busy  <= 1'b1;
            cnt   <= 2'd0;
            sum   <= 8'd0;
          end
        end
        DATA: begin
          if (Rx_Done) begin
            // a HEADER value here is payload
            shreg <= {shreg[23:0], Rx_Data};
            sum   <= sum + Rx_Data;
            cnt   <= cnt + 2'd1;
            tcnt  <= '0;
            if (cnt == 2'd3) state <= CHK;
          end else if (expired) begin
            Frame_Err <= 1'b1;
            state     <= IDLE;
            Busy      <= 1'b0;
            cnt       <= 2'd0;
            tcnt      <= '0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        CHK: begin
          if (Rx_Done) begin
            state <= IDLE;
            Busy  <= 1'b0;
            cnt   <= 2'd0;
            tcnt  <= '0;
            if (Rx_Data == sum) begin
              Disp_Data <= shreg;
              Frame_Ok  <= 1'b1;
            end else begin
              Frame_Err <= 1'b1;
            end
          end else if (expired) begin
            Frame_Err <= 1'b1;
            state     <= IDLE;
            Busy      <= 1'b0;
            cnt       <= 2'd0;
            tcnt      <= '0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
          tcnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_disp_frame_ctrl.sv
// Bench for uart_disp_frame_ctrl: queue-based frame model plus literal checks.
// Drives directed byte streams, compares every cycle at the falling edge.
module tb_uart_disp_frame_ctrl;

  localparam int T = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;
  logic [31:0] disp;
  logic        ok;
  logic        err;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int n_ok = 0;
  int n_err = 0;

  uart_disp_frame_ctrl #(
    .HEADER(8'hAA),
    .TIMEOUT_CYC(T),
    .RESET_DISP(32'h0)
  ) dut (
    .Clk(clk),
    .Reset_n(rst_n),
    .Rx_Data(rx_data),
    .Rx_Done(rx_done),
    .Disp_Data(disp),
    .Frame_Ok(ok),
    .Frame_Err(err),
    .Busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Frame model: bytes collected in a queue, checksum summed at the end
  logic [7:0]  q[$];
  bit          m_busy;
  int          gap;
  logic [31:0] m_disp;
  bit          m_ok;
  bit          m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0;
      q.delete();
      gap = 0;
      m_disp = 32'h0;
      m_ok = 0;
      m_err = 0;
    end else begin
      m_ok = 0;
      m_err = 0;
      if (!m_busy) begin
        if (rx_done && rx_data == 8'hAA) begin
          m_busy = 1;
          q.delete();
          gap = 0;
        end
      end else if (rx_done) begin
        gap = 0;
        if (q.size() < 4) begin
          q.push_back(rx_data);
        end else begin
          int s;
          s = 0;
          foreach (q[i]) s += int'(q[i]);
          if (int'(rx_data) == s % 256) begin
            m_disp = {q[0], q[1], q[2], q[3]};
            m_ok = 1;
          end else begin
            m_err = 1;
          end
          m_busy = 0;
        end
      end else begin
        gap++;
        if (gap == T) begin
          m_err = 1;
          m_busy = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("disp", disp, m_disp);
    check("frame_ok", {31'd0, ok}, {31'd0, m_ok});
    check("frame_err", {31'd0, err}, {31'd0, m_err});
    check("busy", {31'd0, busy}, {31'd0, m_busy});
    if (ok) n_ok++;
    if (err) n_err++;
  end

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_seq(input logic [7:0] s[]);
    foreach (s[i]) send(s[i]);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_disp", disp, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // good frame
    send_seq('{8'hAA, 8'h12, 8'h34, 8'h56, 8'h78, 8'h14});
    idle(2);
    check("t1_disp", disp, 32'h12345678);
    check("t1_ok_cnt", n_ok, 1);
    check("t1_busy", {31'd0, busy}, 32'd0);

    // bad checksum keeps display
    send_seq('{8'hAA, 8'h12, 8'h34, 8'h56, 8'h78, 8'h15});
    idle(2);
    check("t2_disp", disp, 32'h12345678);
    check("t2_err_cnt", n_err, 1);

    // leading junk ignored silently
    send_seq('{8'h00, 8'hFF, 8'hAA, 8'h01,
               8'h02, 8'h03, 8'h04, 8'h0A});
    idle(2);
    check("t3_disp", disp, 32'h01020304);
    check("t3_err_cnt", n_err, 1);

    // timeout then recovery
    send_seq('{8'hAA, 8'h11, 8'h22});
    idle(T + 2);
    check("t4_err_cnt", n_err, 2);
    check("t4_busy", {31'd0, busy}, 32'd0);
    send_seq('{8'hAA, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h2E});
    idle(2);
    check("t4_disp", disp, 32'h0A0B0C0D);

    // byte on the last allowed cycle wins over timeout
    send_seq('{8'hAA, 8'h05});
    idle(T - 1);
    send_seq('{8'h06, 8'h07, 8'h08, 8'h1A});
    idle(2);
    check("tb_disp", disp, 32'h05060708);
    check("tb_err_cnt", n_err, 2);

    // header inside payload
    send_seq('{8'hAA, 8'hAA, 8'h00, 8'h00, 8'h01, 8'hAB});
    idle(1);
    check("t5_disp", disp, 32'hAA000001);

    // back-to-back frames, second with wrapping checksum
    send_seq('{8'hAA, 8'h12, 8'h34, 8'h56, 8'h78, 8'h14,
               8'hAA, 8'hFF, 8'hFF, 8'hFF, 8'h03, 8'h00});
    idle(2);
    check("bb_disp", disp, 32'hFFFFFF03);
    check("bb_ok_cnt", n_ok, 7);

    // reset mid-frame
    send_seq('{8'hAA, 8'h12});
    rst_n = 1'b0;
    #2;
    check("t6_rst_disp", disp, 32'h0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_seq('{8'h34, 8'h56, 8'h78, 8'h14});
    idle(2);
    check("t6_disp", disp, 32'h0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_ok_cnt", n_ok, 7);
    check("t6_err_cnt", n_err, 2);

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
